// File: rtl/rs232_rx_fifo_pkg.sv
// rs232_rx_fifo_pkg
// Shared bus widths, default register addresses, bus FSM state codes and
// status-word bit positions for the RS232 receive FIFO. No ports.
package rs232_rx_fifo_pkg;

   localparam int unsigned ADDR_SIZE = 16;
   localparam int unsigned DATA_SIZE = 32;

   // Data register; the status/control word sits at the next address.
   localparam logic [ADDR_SIZE-1:0] RS232_DATA_ADDR = 16'hFF10;

   // Bus FSM state codes.
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RESP = 1'b1;

   // Status word layout: {overflow, full, empty, count[4:0]}.
   localparam int unsigned STAT_OVF_BIT   = 7;
   localparam int unsigned STAT_FULL_BIT  = 6;
   localparam int unsigned STAT_EMPTY_BIT = 5;

   // Control word bits written to the status address.
   localparam int unsigned CTRL_FLUSH_BIT   = 0;
   localparam int unsigned CTRL_CLR_OVF_BIT = 1;

   function automatic logic [7:0] status_byte(input logic       ovf,
                                              input logic       full,
                                              input logic       empty,
                                              input logic [4:0] count);
      logic [7:0] s;
      s                 = {3'b000, count};
      s[STAT_OVF_BIT]   = ovf;
      s[STAT_FULL_BIT]  = full;
      s[STAT_EMPTY_BIT] = empty;
      return s;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Byte-wide synchronous FIFO with 2**DEPTH_LOG2 entries.
// Ports:
//   clk, rst       - clock, asynchronous active-low reset
//   push, wr_data  - write request and byte (accepted when not full, or when
//                    a pop happens on the same edge)
//   pop            - read request (ignored when empty)
//   flush          - empties the FIFO; overrides push and pop
//   rd_data        - byte at the head, valid while not empty
//   count          - occupancy, 0 .. 2**DEPTH_LOG2
//   full, empty    - occupancy flags
module sync_fifo #(
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic                pop,
   input  logic                flush,
   input  logic [7:0]          wr_data,
   output logic [7:0]          rd_data,
   output logic [DEPTH_LOG2:0] count,
   output logic                full,
   output logic                empty
);

   localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [7:0]            mem [2**DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] wr_ptr_q;
   logic [DEPTH_LOG2-1:0] rd_ptr_q;
   logic [DEPTH_LOG2:0]   count_q;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (count_q == DEPTH);
   assign empty   = (count_q == '0);
   assign do_pop  = pop & ~empty & ~flush;
   // A pop on the same edge frees the slot, so a full FIFO still accepts.
   assign do_push = push & (~full | do_pop) & ~flush;
   assign rd_data = mem[rd_ptr_q];
   assign count   = count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop) begin
            count_q <= count_q + 1'b1;
         end else if (do_pop && !do_push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   // Storage needs no reset; only entries below count are ever read out.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/rs232_rx_fifo.sv
// rs232_rx_fifo
// Buffers bytes from a UART receiver and exposes them on a simple CPU bus.
// Reading DATA_ADDR pops one byte (stalling the CPU while empty); the status
// address reads {overflow, full, empty, count} and accepts flush / clear-
// overflow writes.
// Ports:
//   clk, rst              - clock, asynchronous active-low reset
//   clk_oe                - bus phase enable; the bus FSM moves only when set
//   rx_strobe, rx_byte    - one-cycle pulse with a new received byte
//   addr_in, data_in      - bus request address and write data
//   read_q, write_q       - bus read / write requests
//   read_dn, write_dn     - one clk_oe cycle completion pulses
//   addr_out, data_out    - response address / data, zero outside a done pulse
//   rw_halt_out           - CPU stall while a data read waits on an empty FIFO
//   rx_nempty             - FIFO holds at least one byte
module rs232_rx_fifo
   import rs232_rx_fifo_pkg::*;
#(
   parameter logic [ADDR_SIZE-1:0] DATA_ADDR   = RS232_DATA_ADDR,
   parameter logic [ADDR_SIZE-1:0] STATUS_ADDR = RS232_DATA_ADDR + 1'b1,
   parameter int unsigned          DEPTH_LOG2  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clk_oe,
   input  logic                 rx_strobe,
   input  logic [7:0]           rx_byte,
   input  logic [ADDR_SIZE-1:0] addr_in,
   input  logic [DATA_SIZE-1:0] data_in,
   input  logic                 read_q,
   input  logic                 write_q,
   output logic                 read_dn,
   output logic                 write_dn,
   output logic [ADDR_SIZE-1:0] addr_out,
   output logic [DATA_SIZE-1:0] data_out,
   output logic                 rw_halt_out,
   output logic                 rx_nempty
);

   logic [7:0]            fifo_rd_data;
   logic [DEPTH_LOG2:0]   fifo_count;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  pop;
   logic                  flush;
   logic                  ovf_clr;
   logic [4:0]            count5;

   logic [0:0]            state_q, state_d;
   logic [DATA_SIZE-1:0]  data_q, data_d;
   logic [ADDR_SIZE-1:0]  addr_q, addr_d;
   logic                  is_rd_q, is_rd_d;
   logic                  rd_done_q, rd_done_d;
   logic                  wr_done_q, wr_done_d;
   logic                  ovf_q, ovf_d;
   logic                  idle_ready;
   logic                  unused_data;

   assign unused_data = ^data_in[DATA_SIZE-1:2];
   assign count5      = 5'(fifo_count);

   sync_fifo #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (rx_strobe),
      .pop     (pop),
      .flush   (flush),
      .wr_data (rx_byte),
      .rd_data (fifo_rd_data),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // The done pulse is shown while already back in IDLE; new requests are
   // held off until it clears so a slow master cannot trigger a second pop.
   assign idle_ready = (state_q == ST_IDLE) & ~rd_done_q & ~wr_done_q;

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      addr_d    = addr_q;
      is_rd_d   = is_rd_q;
      rd_done_d = rd_done_q;
      wr_done_d = wr_done_q;
      pop       = 1'b0;
      flush     = 1'b0;
      ovf_clr   = 1'b0;
      if (clk_oe) begin
         rd_done_d = 1'b0;
         wr_done_d = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (idle_ready) begin
                  if (read_q) begin
                     if (addr_in == DATA_ADDR && !fifo_empty) begin
                        pop     = 1'b1;
                        data_d  = DATA_SIZE'(fifo_rd_data);
                        addr_d  = addr_in;
                        is_rd_d = 1'b1;
                        state_d = ST_RESP;
                     end else if (addr_in == STATUS_ADDR) begin
                        data_d  = DATA_SIZE'(status_byte(ovf_q, fifo_full, fifo_empty, count5));
                        addr_d  = addr_in;
                        is_rd_d = 1'b1;
                        state_d = ST_RESP;
                     end
                  end else if (write_q) begin
                     if (addr_in == STATUS_ADDR) begin
                        flush   = data_in[CTRL_FLUSH_BIT];
                        ovf_clr = data_in[CTRL_CLR_OVF_BIT];
                        data_d  = '0;
                        addr_d  = addr_in;
                        is_rd_d = 1'b0;
                        state_d = ST_RESP;
                     end else if (addr_in == DATA_ADDR) begin
                        data_d  = '0;
                        addr_d  = addr_in;
                        is_rd_d = 1'b0;
                        state_d = ST_RESP;
                     end
                  end
               end
            end
            ST_RESP: begin
               rd_done_d = is_rd_q;
               wr_done_d = ~is_rd_q;
               state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Overflow only records bytes lost to a full FIFO; a byte discarded by a
   // flush on the same edge is not an overflow. A new loss beats a clear.
   always_comb begin
      ovf_d = ovf_q;
      if (ovf_clr) ovf_d = 1'b0;
      if (rx_strobe && fifo_full && !pop && !flush) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         data_q    <= '0;
         addr_q    <= '0;
         is_rd_q   <= 1'b0;
         rd_done_q <= 1'b0;
         wr_done_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         addr_q    <= addr_d;
         is_rd_q   <= is_rd_d;
         rd_done_q <= rd_done_d;
         wr_done_q <= wr_done_d;
         ovf_q     <= ovf_d;
      end
   end

   assign read_dn     = rd_done_q;
   assign write_dn    = wr_done_q;
   assign addr_out    = (rd_done_q | wr_done_q) ? addr_q : '0;
   assign data_out    = rd_done_q ? data_q : '0;
   assign rw_halt_out = rst & idle_ready & read_q & (addr_in == DATA_ADDR) & fifo_empty;
   assign rx_nempty   = ~fifo_empty;

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// tb_rs232_rx_fifo
// Self-checking bench for rs232_rx_fifo: a byte queue models the FIFO and
// overflow flag; bus reads are compared against it as they complete.
module tb_rs232_rx_fifo;
   import rs232_rx_fifo_pkg::*;

   localparam logic [ADDR_SIZE-1:0] DADDR = RS232_DATA_ADDR;
   localparam logic [ADDR_SIZE-1:0] SADDR = RS232_DATA_ADDR + 1'b1;
   localparam logic [ADDR_SIZE-1:0] OADDR = 16'h0040;
   localparam int                   DEPTH = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 clk_oe = 1'b0;
   logic                 rx_strobe;
   logic [7:0]           rx_byte;
   logic [ADDR_SIZE-1:0] addr_in;
   logic [DATA_SIZE-1:0] data_in;
   logic                 read_q;
   logic                 write_q;
   logic                 read_dn;
   logic                 write_dn;
   logic [ADDR_SIZE-1:0] addr_out;
   logic [DATA_SIZE-1:0] data_out;
   logic                 rw_halt_out;
   logic                 rx_nempty;

   int          checks = 0;
   int          errors = 0;
   int unsigned oe_edges = 0;
   logic [7:0]  sb_q[$];
   logic        sb_ovf = 1'b0;

   rs232_rx_fifo #(
      .DEPTH_LOG2(4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .clk_oe      (clk_oe),
      .rx_strobe   (rx_strobe),
      .rx_byte     (rx_byte),
      .addr_in     (addr_in),
      .data_in     (data_in),
      .read_q      (read_q),
      .write_q     (write_q),
      .read_dn     (read_dn),
      .write_dn    (write_dn),
      .addr_out    (addr_out),
      .data_out    (data_out),
      .rw_halt_out (rw_halt_out),
      .rx_nempty   (rx_nempty)
   );

   always #5 clk = ~clk;

   // clk_oe runs at half rate; oe_edges counts clk edges taken with clk_oe=1.
   always @(posedge clk) begin
      if (clk_oe) oe_edges <= oe_edges + 1;
      clk_oe <= ~clk_oe;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_status();
      int n;
      n = sb_q.size();
      return {sb_ovf, (n == DEPTH), (n == 0), 5'(n)};
   endfunction

   task automatic inject(input logic [7:0] b);
      @(negedge clk);
      rx_strobe = 1'b1;
      rx_byte   = b;
      @(negedge clk);
      rx_strobe = 1'b0;
      if (sb_q.size() < DEPTH) sb_q.push_back(b);
      else sb_ovf = 1'b1;
   endtask

   task automatic start_req(input logic wr, input logic [ADDR_SIZE-1:0] a,
                            input logic [DATA_SIZE-1:0] d, output int unsigned start);
      @(negedge clk);
      addr_in = a;
      data_in = d;
      read_q  = ~wr;
      write_q = wr;
      start   = oe_edges;
   endtask

   // exp_lat of 0 skips the latency check (stalled reads).
   task automatic wait_done(input logic wr, input int unsigned start, input int unsigned exp_lat,
                            output logic [DATA_SIZE-1:0] rdata);
      logic        got;
      int unsigned seen;
      got   = 1'b0;
      rdata = '0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if ((wr ? write_dn : read_dn) === 1'b1) got = 1'b1;
      end
      check_eq("done_seen", 32'(got), 32'd1);
      if (got) begin
         if (exp_lat != 0) check_eq("latency", oe_edges - start, exp_lat);
         check_eq("done_kind", 32'({read_dn, write_dn}), wr ? 32'd1 : 32'd2);
         check_eq("addr_out", 32'(addr_out), 32'(addr_in));
         if (wr) check_eq("wr_data_out", data_out, 32'd0);
         rdata   = data_out;
         seen    = oe_edges;
         read_q  = 1'b0;
         write_q = 1'b0;
         for (int i = 0; i < 10 && oe_edges == seen; i++) @(negedge clk);
         check_eq("done_width", 32'({read_dn, write_dn, addr_out != '0, data_out != '0}), 32'd0);
      end else begin
         read_q  = 1'b0;
         write_q = 1'b0;
      end
   endtask

   task automatic read_data(input string tag);
      int unsigned          st;
      logic [DATA_SIZE-1:0] d;
      logic [7:0]           e;
      start_req(1'b0, DADDR, '0, st);
      wait_done(1'b0, st, 2, d);
      e = sb_q.pop_front();
      check_eq(tag, d, 32'(e));
   endtask

   task automatic read_status(input string tag, output logic [DATA_SIZE-1:0] d);
      int unsigned st;
      logic [7:0]  e;
      e = exp_status();
      start_req(1'b0, SADDR, '0, st);
      wait_done(1'b0, st, 2, d);
      check_eq(tag, d, 32'(e));
   endtask

   task automatic write_status(input logic [DATA_SIZE-1:0] v);
      int unsigned          st;
      logic [DATA_SIZE-1:0] d;
      start_req(1'b1, SADDR, v, st);
      wait_done(1'b1, st, 2, d);
      if (v[0]) sb_q.delete();
      if (v[1]) sb_ovf = 1'b0;
   endtask

   initial begin
      int unsigned          st;
      logic [DATA_SIZE-1:0] d;
      logic [7:0]           e;
      logic                 bad;

      rst       = 1'b1;
      rx_strobe = 1'b0;
      rx_byte   = '0;
      addr_in   = DADDR;
      data_in   = '0;
      read_q    = 1'b1;
      write_q   = 1'b0;
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_read_dn", 32'(read_dn), 32'd0);
      check_eq("rst_write_dn", 32'(write_dn), 32'd0);
      check_eq("rst_addr_out", 32'(addr_out), 32'd0);
      check_eq("rst_data_out", data_out, 32'd0);
      check_eq("rst_halt", 32'(rw_halt_out), 32'd0);
      check_eq("rst_nempty", 32'(rx_nempty), 32'd0);
      read_q = 1'b0;
      rst    = 1'b1;
      read_status("status_after_rst", d);

      // Two bytes in, two reads out in order.
      inject(8'h41);
      inject(8'h42);
      check_eq("nempty_set", 32'(rx_nempty), 32'd1);
      read_data("rd_0x41");
      read_data("rd_0x42");
      check_eq("nempty_clr", 32'(rx_nempty), 32'd0);

      // Read while empty stalls until a byte arrives.
      start_req(1'b0, DADDR, '0, st);
      repeat (4) @(negedge clk);
      check_eq("halt_empty", 32'(rw_halt_out), 32'd1);
      check_eq("no_done_stalled", 32'(read_dn), 32'd0);
      inject(8'h55);
      check_eq("halt_released", 32'(rw_halt_out), 32'd0);
      wait_done(1'b0, st, 0, d);
      e = sb_q.pop_front();
      check_eq("rd_0x55", d, 32'(e));

      // Unmapped addresses: no done, no halt.
      bad = 1'b0;
      for (int w = 0; w < 2; w++) begin
         @(negedge clk);
         addr_in = OADDR;
         read_q  = (w == 0);
         write_q = (w == 1);
         repeat (8) begin
            @(negedge clk);
            if (read_dn || write_dn || rw_halt_out) bad = 1'b1;
         end
         read_q  = 1'b0;
         write_q = 1'b0;
      end
      check_eq("other_addr_ignored", 32'(bad), 32'd0);

      // Write to the data address is acknowledged and ignored.
      start_req(1'b1, DADDR, 32'hAB, st);
      wait_done(1'b1, st, 2, d);
      check_eq("data_write_nop", 32'(rx_nempty), 32'd0);

      // Overfill: 17th byte lost, overflow sticky.
      for (int i = 0; i < DEPTH + 1; i++) inject(8'h60 + 8'(i));
      read_status("status_ovf_full", d);
      check_eq("status_0xd0", d, 32'hD0);

      // Flush and clear overflow.
      write_status(32'h3);
      read_status("status_flushed", d);
      check_eq("status_0x20", d, 32'h20);

      // Refill, then push and pop on the same edge while full.
      for (int i = 0; i < DEPTH; i++) inject(8'h80 + 8'(i));
      read_status("status_full", d);
      @(negedge clk);
      if (!clk_oe) @(negedge clk);
      addr_in   = DADDR;
      read_q    = 1'b1;
      rx_strobe = 1'b1;
      rx_byte   = 8'hA5;
      st        = oe_edges;
      @(negedge clk);
      rx_strobe = 1'b0;
      e = sb_q.pop_front();
      sb_q.push_back(8'hA5);
      wait_done(1'b0, st, 2, d);
      check_eq("rd_full_pop", d, 32'(e));
      read_status("status_full_no_ovf", d);
      check_eq("status_0x50", d, 32'h50);
      for (int i = 0; i < DEPTH; i++) read_data("drain");

      // Reset during the response phase aborts the read.
      inject(8'h77);
      start_req(1'b0, SADDR, '0, st);
      for (int i = 0; i < 20 && oe_edges < st + 1; i++) @(negedge clk);
      rst    = 1'b0;
      read_q = 1'b0;
      #1;
      check_eq("mid_rst_read_dn", 32'(read_dn), 32'd0);
      check_eq("mid_rst_data_out", data_out, 32'd0);
      check_eq("mid_rst_addr_out", 32'(addr_out), 32'd0);
      check_eq("mid_rst_nempty", 32'(rx_nempty), 32'd0);
      sb_q.delete();
      sb_ovf = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      bad = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (read_dn || write_dn) bad = 1'b1;
      end
      check_eq("no_stray_done", 32'(bad), 32'd0);
      read_status("status_after_abort", d);
      check_eq("abort_0x20", d, 32'h20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
